sobel_edge_detect: RTL and testbench

//  Streaming 3x3 Sobel edge detector downstream of bilateral_filter; consumes its post_img_* stream (8-bit gray).

---
 rtl/img_proc_pkg.sv | 17 +
 rtl/sobel_line_buffer.sv | 38 +++
 rtl/sobel_edge_detect.sv | 185 ++++++++++++++++++
 tb/tb_sobel_edge_detect.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// Shared image-processing types and defaults for the pixel-stream blocks.
//   pixel_t   : 8-bit gray pixel
//   grad_t    : signed 11-bit Sobel gradient (range -1020..+1020)
//   mag_t     : unsigned 11-bit gradient magnitude |Gx|+|Gy| (0..2040)
//   SOBEL_LAT : input-to-output latency of sobel_edge_detect in clocks
//   IMG_W/H   : default active frame size
package img_proc_pkg;

    typedef logic        [7:0]  pixel_t;
    typedef logic signed [10:0] grad_t;
    typedef logic        [10:0] mag_t;

    localparam int SOBEL_LAT = 4;
    localparam int IMG_W     = 1280;
    localparam int IMG_H     = 720;

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: simple dual-port RAM, one write and one registered read
// per clock. A read and a write to the same address in the same clock return the
// old contents (read-before-write), which the window builder relies on.
// Contents are never reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address (0..DEPTH-1)
//   wr_data  in   write data
//   rd_en    in   read strobe; rd_data holds when low
//   rd_addr  in   read address (0..DEPTH-1)
//   rd_data  out  registered read data, one clock after rd_en
module sobel_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector on an 8-bit gray pixel stream.
// Sync and valid are passed through a plain 4-deep delay line; the pixel at stream
// position (r,c) leaves as the edge result for (r-1,c-1), 4 clocks after entry.
// Pixels in the first two rows or columns of a frame produce 0x00.
// Build option SOBEL_MAG_OUT_EN: when defined, the output is min(|Gx|+|Gy|, 255)
// as a gray magnitude and THRESH is ignored; when undefined, the output is the
// binary map 0xFF (|Gx|+|Gy| >= THRESH) / 0x00.
// Ports:
//   clk             in   clock
//   rst_n           in   synchronous reset, active low
//   pre_img_vsync   in   frame sync, active high
//   pre_img_hsync   in   line sync, active high
//   pre_img_valid   in   active-pixel qualifier
//   pre_img_data    in   gray pixel (8)
//   post_img_vsync  out  pre_img_vsync delayed 4 clocks
//   post_img_hsync  out  pre_img_hsync delayed 4 clocks
//   post_img_valid  out  pre_img_valid delayed 4 clocks
//   post_img_data   out  edge result (8), 0x00 whenever post_img_valid is low
module sobel_edge_detect
    import img_proc_pkg::*;
#(
    parameter int          IMG_WIDTH  = IMG_W,
    parameter int          IMG_HEIGHT = IMG_H,
    parameter logic [10:0] THRESH     = 11'd128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_img_vsync,
    input  logic       pre_img_hsync,
    input  logic       pre_img_valid,
    input  logic [7:0] pre_img_data,
    output logic       post_img_vsync,
    output logic       post_img_hsync,
    output logic       post_img_valid,
    output logic [7:0] post_img_data
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] col_cnt;
    logic [CW-1:0] col_p0;
    logic [RW-1:0] row_cnt;
    logic          valid_fall;
    logic          vsync_rise;

    // {vsync, hsync, valid}
    logic [2:0] sync_p0, sync_p1, sync_p2;
    logic       vld_p0, vld_p2;
    logic       border_p0, border_p1, border_p2;

    pixel_t       pix_p0, lb0_q, lb1_q;
    // Window columns, index 0 = row r-2 (top), 1 = row r-1, 2 = row r (bottom)
    pixel_t [2:0] win_l;   // column c-2
    pixel_t [2:0] win_m;   // column c-1
    pixel_t [2:0] col_n;   // column c, straight from the line buffers
    grad_t        gx, gy, gx_p1, gy_p1;
    mag_t         mag_p2;

    // Weighted column/row tap a + 2b + c, widened to the signed gradient width
    function automatic grad_t tap_sum(input pixel_t a, input pixel_t b, input pixel_t c);
        return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
    endfunction

    // |g|; the gradient never reaches -1024 so negation cannot overflow
    function automatic mag_t abs_grad(input grad_t g);
        return g[10] ? mag_t'(-g) : mag_t'(g);
    endfunction

`ifdef SOBEL_MAG_OUT_EN
    function automatic pixel_t edge_value(input mag_t m);
        return (m > 11'd255) ? 8'hFF : m[7:0];
    endfunction
`else
    function automatic pixel_t edge_value(input mag_t m);
        return (m >= THRESH) ? 8'hFF : 8'h00;
    endfunction
`endif

    assign vld_p0     = sync_p0[0];
    assign vld_p2     = sync_p2[0];
    assign valid_fall = vld_p0 & ~pre_img_valid;
    assign vsync_rise = pre_img_vsync & ~sync_p0[2];

    // col_cnt is the column of the pixel currently on the input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            if (valid_fall) begin
                col_cnt <= '0;
            end else if (pre_img_valid) begin
                col_cnt <= (col_cnt == CW'(IMG_WIDTH - 1)) ? '0 : col_cnt + 1'b1;
            end
            if (vsync_rise) begin
                row_cnt <= '0;
            end else if (valid_fall && row_cnt != RW'(IMG_HEIGHT - 1)) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // lb0 holds row r-1; lb1 is refilled from lb0's read data one clock later,
    // so it holds row r-2 by the time the next line reads it.
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(8)) u_lb0 (
        .clk     (clk),
        .wr_en   (pre_img_valid),
        .wr_addr (col_cnt),
        .wr_data (pre_img_data),
        .rd_en   (pre_img_valid),
        .rd_addr (col_cnt),
        .rd_data (lb0_q)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(8)) u_lb1 (
        .clk     (clk),
        .wr_en   (vld_p0),
        .wr_addr (col_p0),
        .wr_data (lb0_q),
        .rd_en   (pre_img_valid),
        .rd_addr (col_cnt),
        .rd_data (lb1_q)
    );

    // ---- stage 0: line-buffer read, pixel capture, border flag ----
    always_ff @(posedge clk) begin
        pix_p0 <= pre_img_data;
        col_p0 <= col_cnt;
    end

    assign col_n = {pix_p0, lb0_q, lb1_q};

    always_comb begin
        gx = tap_sum(col_n[0], col_n[1], col_n[2]) - tap_sum(win_l[0], win_l[1], win_l[2]);
        gy = tap_sum(win_l[2], win_m[2], col_n[2]) - tap_sum(win_l[0], win_m[0], col_n[0]);
    end

    // ---- stage 1: gradients; window shifts only on valid pixels ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_l <= '0;
            win_m <= '0;
        end else if (vld_p0) begin
            win_l <= win_m;
            win_m <= col_n;
        end
    end

    always_ff @(posedge clk) begin
        gx_p1 <= gx;
        gy_p1 <= gy;
        // ---- stage 2: magnitude ----
        mag_p2 <= abs_grad(gx_p1) + abs_grad(gy_p1);
    end

    // Sync delay line, border flag pipeline and output stage (stage 3)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0        <= '0;
            sync_p1        <= '0;
            sync_p2        <= '0;
            border_p0      <= 1'b0;
            border_p1      <= 1'b0;
            border_p2      <= 1'b0;
            post_img_vsync <= 1'b0;
            post_img_hsync <= 1'b0;
            post_img_valid <= 1'b0;
            post_img_data  <= 8'h00;
        end else begin
            sync_p0        <= {pre_img_vsync, pre_img_hsync, pre_img_valid};
            sync_p1        <= sync_p0;
            sync_p2        <= sync_p1;
            border_p0      <= (row_cnt < RW'(2)) || (col_cnt < CW'(2));
            border_p1      <= border_p0;
            border_p2      <= border_p1;
            // ---- stage 3: threshold / saturate, gated by valid and border ----
            post_img_vsync <= sync_p2[2];
            post_img_hsync <= sync_p2[1];
            post_img_valid <= sync_p2[0];
            post_img_data  <= (vld_p2 && !border_p2) ? edge_value(mag_p2) : 8'h00;
        end
    end

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Directed bench for sobel_edge_detect on a small 8x6 frame. Each stimulus cycle
// records the expected output (sync/valid plus a hand-derived edge value), which is
// compared against the DUT four clocks later. Any clock sampled with rst_n low
// within the last four edges forces an all-zero expectation.
module tb_sobel_edge_detect;

    localparam int W = 8;
    localparam int H = 6;

    localparam int P_FLAT    = 0;
    localparam int P_VSTEP   = 1;  // 0 for col<4, v for col>=4
    localparam int P_VSTEPDN = 2;  // v for col<4, 0 for col>=4
    localparam int P_HSTEP   = 3;  // 0 for row<3, v for row>=3
    localparam int P_IMP     = 4;  // single pixel v at (2,3)

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_img_vsync, pre_img_hsync, pre_img_valid;
    logic [7:0] pre_img_data;
    logic       post_img_vsync, post_img_hsync, post_img_valid;
    logic [7:0] post_img_data;

    always #5 clk = ~clk;

    sobel_edge_detect #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .THRESH     (11'd128)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pre_img_vsync  (pre_img_vsync),
        .pre_img_hsync  (pre_img_hsync),
        .pre_img_valid  (pre_img_valid),
        .pre_img_data   (pre_img_data),
        .post_img_vsync (post_img_vsync),
        .post_img_hsync (post_img_hsync),
        .post_img_valid (post_img_valid),
        .post_img_data  (post_img_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rst_left = 0;
    logic dc = 1'b0;

    logic       hist_rst  [8];
    logic [2:0] hist_sync [8];
    logic [7:0] hist_data [8];
    logic       hist_chk  [8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int pat, input int v, input int r, input int c);
        case (pat)
            P_FLAT:    return 8'(v);
            P_VSTEP:   return (c >= 4) ? 8'(v) : 8'h00;
            P_VSTEPDN: return (c < 4) ? 8'(v) : 8'h00;
            P_HSTEP:   return (r >= 3) ? 8'(v) : 8'h00;
            P_IMP:     return (r == 2 && c == 3) ? 8'(v) : 8'h00;
            default:   return 8'h00;
        endcase
    endfunction

    // Hand-derived |Gx|+|Gy| at stream position (r,c), window rows r-2..r, cols c-2..c:
    //   vertical step: window straddles col 4 only for c=4,5 -> 4v
    //   horizontal step: window straddles row 3 only for r=3,4 -> 4v
    //   impulse: any non-centre window position weighs 2 in |Gx|+|Gy| -> 2v
    function automatic logic [7:0] exp_px(input int pat, input int v, input int r, input int c);
        int m;
        if (r < 2 || c < 2) return 8'h00;
        m = 0;
        case (pat)
            P_VSTEP, P_VSTEPDN: if (c == 4 || c == 5) m = 4 * v;
            P_HSTEP:            if (r == 3 || r == 4) m = 4 * v;
            P_IMP:              if (r <= 4 && c >= 3 && c <= 5 && !(r == 3 && c == 4)) m = 2 * v;
            default:            m = 0;
        endcase
`ifdef SOBEL_MAG_OUT_EN
        return (m > 255) ? 8'hFF : 8'(m);
`else
        return (m >= 128) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic step(input logic rstv, input logic vs, input logic hs, input logic vl,
                        input logic [7:0] d, input logic chk, input logic [7:0] ed);
        logic in_rst;
        int   k;
        @(posedge clk);
        #1;
        in_rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!hist_rst[(cyc - i) & 7]) in_rst = 1'b1;
        end
        k = (cyc - 4) & 7;
        if (in_rst) begin
            check_val("rst_vsync", 32'(post_img_vsync), 32'd0);
            check_val("rst_hsync", 32'(post_img_hsync), 32'd0);
            check_val("rst_valid", 32'(post_img_valid), 32'd0);
            check_val("rst_data",  32'(post_img_data),  32'd0);
        end else begin
            check_val("vsync", 32'(post_img_vsync), 32'(hist_sync[k][2]));
            check_val("hsync", 32'(post_img_hsync), 32'(hist_sync[k][1]));
            check_val("valid", 32'(post_img_valid), 32'(hist_sync[k][0]));
            if (hist_chk[k]) check_val("data", 32'(post_img_data), 32'(hist_data[k]));
        end
        rst_n         = rstv;
        pre_img_vsync = vs;
        pre_img_hsync = hs;
        pre_img_valid = vl;
        pre_img_data  = d;
        hist_rst[cyc & 7]  = rstv;
        hist_sync[cyc & 7] = {vs, hs, vl};
        hist_data[cyc & 7] = ed;
        hist_chk[cyc & 7]  = chk;
        cyc++;
    endtask

    // Stream one cycle; once a mid-frame reset starts, data checks stop for the
    // rest of that frame but sync/valid and reset-zero checks continue.
    task automatic stream(input logic vs, input logic hs, input logic vl,
                          input logic [7:0] d, input logic [7:0] ed);
        logic rv;
        rv = (rst_left > 0) ? 1'b0 : 1'b1;
        if (rst_left > 0) begin
            rst_left--;
            dc = 1'b1;
        end
        step(rv, vs, hs, vl, d, !dc, vl ? ed : 8'h00);
    endtask

    task automatic run_frame(input int pat, input int v, input int rst_row);
        dc = 1'b0;
        repeat (3) stream(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) stream(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int r = 0; r < H; r++) begin
            repeat (2) stream(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
            repeat (2) stream(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            for (int c = 0; c < W; c++) begin
                if (r == rst_row && c == 2) rst_left = 10;
                stream(1'b0, 1'b0, 1'b1, pix_val(pat, v, r, c), exp_px(pat, v, r, c));
            end
            repeat (2) stream(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        repeat (4) stream(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            hist_rst[i]  = 1'b0;
            hist_sync[i] = 3'b000;
            hist_data[i] = 8'h00;
            hist_chk[i]  = 1'b1;
        end
        rst_n         = 1'b0;
        pre_img_vsync = 1'b0;
        pre_img_hsync = 1'b0;
        pre_img_valid = 1'b0;
        pre_img_data  = 8'h00;

        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);

        run_frame(P_FLAT,    8'h80, -1);
        run_frame(P_VSTEP,   8'hFF, -1);
        run_frame(P_VSTEPDN, 8'h10, -1);
        run_frame(P_HSTEP,   8'h20, -1);
        run_frame(P_HSTEP,   8'h1F, -1);
        run_frame(P_IMP,     8'h40, -1);
        run_frame(P_IMP,     8'h3F, -1);
        run_frame(P_VSTEP,   8'hFF, 3);
        run_frame(P_IMP,     8'h40, -1);
        run_frame(P_VSTEPDN, 8'hFF, -1);

        repeat (8) stream(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
